// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the GPR and FPR write ports between ALU (A) and FPU/load (B) requesters.
// Accept in cycle N drives the write port in N+1; same-file conflicts are round-robin, and the loser holds its request.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ZERO_X0 = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_is_fp,
  input  logic [4:0]        a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_is_fp,
  input  logic [4:0]        b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              gpr_reg_write,
  output logic [4:0]        gpr_write_reg,
  output logic [DATA_W-1:0] gpr_write_data,
  output logic              fpr_reg_write,
  output logic [4:0]        fpr_write_reg,
  output logic [DATA_W-1:0] fpr_write_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ptr_gpr_q, ptr_gpr_d;
  logic              ptr_fpr_q, ptr_fpr_d;
  logic              gpr_we_q, gpr_we_d;
  logic [4:0]        gpr_rd_q, gpr_rd_d;
  logic [DATA_W-1:0] gpr_dat_q, gpr_dat_d;
  logic              fpr_we_q, fpr_we_d;
  logic [4:0]        fpr_rd_q, fpr_rd_d;
  logic [DATA_W-1:0] fpr_dat_q, fpr_dat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic conflict, ptr_sel, a_acc, b_acc, stall;

  assign conflict = a_valid && b_valid && (a_is_fp == b_is_fp);
  assign ptr_sel  = a_is_fp ? ptr_fpr_q : ptr_gpr_q;
  assign a_ready  = !reset && (!conflict || !ptr_sel);
  assign b_ready  = !reset && (!conflict || ptr_sel);
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign stall    = (a_valid && !a_ready) || (b_valid && !b_ready);

  always_comb begin
    ptr_gpr_d = ptr_gpr_q;
    ptr_fpr_d = ptr_fpr_q;
    gpr_we_d  = 1'b0;
    gpr_rd_d  = gpr_rd_q;
    gpr_dat_d = gpr_dat_q;
    fpr_we_d  = 1'b0;
    fpr_rd_d  = fpr_rd_q;
    fpr_dat_d = fpr_dat_q;
    cnt_d     = cnt_q;

    // The pointer moves to the loser, so the loser wins the next conflict in that file.
    if (conflict && !a_is_fp) ptr_gpr_d = ~ptr_gpr_q;
    if (conflict && a_is_fp)  ptr_fpr_d = ~ptr_fpr_q;

    if (a_acc && !a_is_fp) begin
      gpr_we_d  = (ZERO_X0 == 0) || (a_rd != 5'd0);
      gpr_rd_d  = a_rd;
      gpr_dat_d = a_data;
    end else if (b_acc && !b_is_fp) begin
      gpr_we_d  = (ZERO_X0 == 0) || (b_rd != 5'd0);
      gpr_rd_d  = b_rd;
      gpr_dat_d = b_data;
    end

    if (a_acc && a_is_fp) begin
      fpr_we_d  = 1'b1;
      fpr_rd_d  = a_rd;
      fpr_dat_d = a_data;
    end else if (b_acc && b_is_fp) begin
      fpr_we_d  = 1'b1;
      fpr_rd_d  = b_rd;
      fpr_dat_d = b_data;
    end

    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_gpr_q <= 1'b0;
      ptr_fpr_q <= 1'b0;
      gpr_we_q  <= 1'b0;
      gpr_rd_q  <= '0;
      gpr_dat_q <= '0;
      fpr_we_q  <= 1'b0;
      fpr_rd_q  <= '0;
      fpr_dat_q <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_gpr_q <= ptr_gpr_d;
      ptr_fpr_q <= ptr_fpr_d;
      gpr_we_q  <= gpr_we_d;
      gpr_rd_q  <= gpr_rd_d;
      gpr_dat_q <= gpr_dat_d;
      fpr_we_q  <= fpr_we_d;
      fpr_rd_q  <= fpr_rd_d;
      fpr_dat_q <= fpr_dat_d;
      cnt_q     <= cnt_d;
    end
  end

  // Masking with reset drops a write registered just before a reset edge.
  assign gpr_reg_write  = gpr_we_q && !reset;
  assign gpr_write_reg  = gpr_rd_q;
  assign gpr_write_data = gpr_dat_q;
  assign fpr_reg_write  = fpr_we_q && !reset;
  assign fpr_write_reg  = fpr_rd_q;
  assign fpr_write_data = fpr_dat_q;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: fixed vectors with hand-computed expectations.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, a_ready, a_is_fp;
  logic [4:0]        a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready, b_is_fp;
  logic [4:0]        b_rd;
  logic [DATA_W-1:0] b_data;
  logic              gpr_reg_write, fpr_reg_write;
  logic [4:0]        gpr_write_reg, fpr_write_reg;
  logic [DATA_W-1:0] gpr_write_data, fpr_write_data;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] gpr_mem [32];

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ZERO_X0(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_is_fp(a_is_fp), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_is_fp(b_is_fp), .b_rd(b_rd), .b_data(b_data),
    .gpr_reg_write(gpr_reg_write), .gpr_write_reg(gpr_write_reg), .gpr_write_data(gpr_write_data),
    .fpr_reg_write(fpr_reg_write), .fpr_write_reg(fpr_write_reg), .fpr_write_data(fpr_write_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Simple GPR model fed from the write port.
  always @(posedge clk)
    if (gpr_reg_write) gpr_mem[gpr_write_reg] <= gpr_write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic fp, input logic [4:0] rd, input logic [31:0] d);
    a_valid = v; a_is_fp = fp; a_rd = rd; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic fp, input logic [4:0] rd, input logic [31:0] d);
    b_valid = v; b_is_fp = fp; b_rd = rd; b_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr_mem[i] = '0;
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 5'd3, 32'h1111_1111);
    drive_b(1'b1, 1'b1, 5'd4, 32'h2222_2222);

    // Reset with both requesters valid
    step();
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    step();
    reset = 1'b0;
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("rst_gpr_we", gpr_reg_write, 0);
    chk("rst_fpr_we", fpr_reg_write, 0);
    chk("rst_gpr_reg", gpr_write_reg, 0);
    chk("rst_gpr_dat", gpr_write_data, 0);
    chk("rst_fpr_dat", fpr_write_data, 0);
    chk("rst_stall", stall_cnt, 0);

    // Different files, same cycle
    drive_a(1'b1, 1'b0, 5'd5, 32'h1234_5678);
    drive_b(1'b1, 1'b1, 5'd5, 32'h3F80_0000);
    #1;
    chk("split_a_ready", a_ready, 1);
    chk("split_b_ready", b_ready, 1);
    step();
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    chk("split_gpr_we", gpr_reg_write, 1);
    chk("split_gpr_reg", gpr_write_reg, 5);
    chk("split_gpr_dat", gpr_write_data, 32'h1234_5678);
    chk("split_fpr_we", fpr_reg_write, 1);
    chk("split_fpr_reg", fpr_write_reg, 5);
    chk("split_fpr_dat", fpr_write_data, 32'h3F80_0000);
    chk("split_stall", stall_cnt, 0);

    // GPR conflicts: A, B, A, B
    drive_a(1'b1, 1'b0, 5'd1, 32'hA1);
    drive_b(1'b1, 1'b0, 5'd2, 32'hB2);
    #1;
    chk("c1_a_ready", a_ready, 1);
    chk("c1_b_ready", b_ready, 0);
    step();
    chk("c1_gpr_reg", gpr_write_reg, 1);
    chk("c1_gpr_dat", gpr_write_data, 32'hA1);
    drive_a(1'b1, 1'b0, 5'd3, 32'hA3);
    #1;
    chk("c2_a_ready", a_ready, 0);
    chk("c2_b_ready", b_ready, 1);
    step();
    chk("c2_gpr_reg", gpr_write_reg, 2);
    drive_b(1'b1, 1'b0, 5'd4, 32'hB4);
    #1;
    chk("c3_a_ready", a_ready, 1);
    chk("c3_b_ready", b_ready, 0);
    step();
    chk("c3_gpr_reg", gpr_write_reg, 3);
    drive_a(1'b1, 1'b0, 5'd9, 32'hA9);
    #1;
    chk("c4_a_ready", a_ready, 0);
    chk("c4_b_ready", b_ready, 1);
    step();
    chk("c4_gpr_reg", gpr_write_reg, 4);
    chk("c4_gpr_dat", gpr_write_data, 32'hB4);
    chk("c4_stall", stall_cnt, 4);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("c5_a_ready", a_ready, 1);
    step();
    chk("c5_gpr_reg", gpr_write_reg, 9);
    chk("c5_stall", stall_cnt, 4);

    // FPR pointer untouched: A wins the first FPR conflict
    drive_a(1'b1, 1'b1, 5'd10, 32'hF10);
    drive_b(1'b1, 1'b1, 5'd11, 32'hF11);
    #1;
    chk("fc_a_ready", a_ready, 1);
    chk("fc_b_ready", b_ready, 0);
    step();
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    chk("fc_fpr_reg", fpr_write_reg, 10);
    chk("fc_gpr_we", gpr_reg_write, 0);
    chk("fc_stall", stall_cnt, 5);

    // x0 suppression on GPR, FPR reg 0 still written
    drive_a(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
    #1;
    chk("x0_a_ready", a_ready, 1);
    step();
    chk("x0_gpr_we", gpr_reg_write, 0);
    drive_a(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    chk("f0_fpr_we", fpr_reg_write, 1);
    chk("f0_fpr_reg", fpr_write_reg, 0);
    chk("f0_fpr_dat", fpr_write_data, 32'hDEAD_BEEF);

    // Saturation: 19 conflict cycles starting from 5
    drive_a(1'b1, 1'b0, 5'd1, 32'h5A);
    drive_b(1'b1, 1'b0, 5'd2, 32'h5B);
    for (int i = 0; i < 10; i++) step();
    chk("sat_reach", stall_cnt, 15);
    for (int i = 0; i < 9; i++) step();
    chk("sat_hold", stall_cnt, 15);
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    step();

    // Accepted write dropped by a following reset
    drive_a(1'b1, 1'b0, 5'd7, 32'hCAFE_0007);
    #1;
    chk("drop_a_ready", a_ready, 1);
    step();
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    #1;
    chk("drop_we_n1", gpr_reg_write, 0);
    step();
    reset = 1'b0;
    #1;
    chk("drop_we_n2", gpr_reg_write, 0);
    chk("drop_stall", stall_cnt, 0);
    chk("drop_mem7", gpr_mem[7], 0);

    // Pointers back to A after reset (GPR pointer was left favouring B)
    drive_a(1'b1, 1'b0, 5'd12, 32'hC12);
    drive_b(1'b1, 1'b0, 5'd13, 32'hC13);
    #1;
    chk("prst_a_ready", a_ready, 1);
    chk("prst_b_ready", b_ready, 0);
    step();
    drive_a(1'b0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("prst_mem12", gpr_mem[12], 32'hC12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of `gpr` and the single write port of `fpr` between two write-back requesters.
- Requester A is the single-cycle integer/ALU path; requester B is the multi-cycle FPU/load path.
- Requests targeting different files are granted in the same cycle. Requests targeting the same file are resolved round-robin, with one fairness pointer per file.
- Write-port outputs are registered and connect directly to `gpr.reg_write/write_reg/write_data` and `fpr.reg_write/write_reg/write_data`.

Parameters:
- DATA_W, 32, write-data width; must match register-file width.
- ZERO_X0, 1, when 1 a GPR write to register 0 is accepted but not performed.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- a_valid  input  1  requester A has a write-back pending
- a_ready  output  1  A accepted this cycle (combinational)
- a_is_fp  input  1  0 = target GPR, 1 = target FPR
- a_rd  input  5  destination register
- a_data  input  DATA_W  write data
- b_valid, b_ready, b_is_fp, b_rd, b_data  same as A, for requester B
- gpr_reg_write  output  1  GPR write enable (registered)
- gpr_write_reg  output  5  GPR write address (registered)
- gpr_write_data  output  DATA_W  GPR write data (registered)
- fpr_reg_write, fpr_write_reg, fpr_write_data  same as GPR, for FPR
- stall_cnt  output  CNT_W  cycles in which any valid request was refused

Behaviour:
- **Handshake:** transfer occurs when x_valid && x_ready at a rising edge. Requesters must not make valid depend on ready. Once asserted, valid and payload stay stable until accepted.
- **Conflict:** a conflict exists when a_valid && b_valid && a_is_fp == b_is_fp.
- **Ready rules (reset = 0):**
  - Without a conflict: a_ready = 1 and b_ready = 1; ready is independent of own valid.
  - With a conflict: only the requester selected by that file's pointer gets ready = 1.
- **Pointers:**
  - ptr_gpr and ptr_fpr are 1 bit each; 0 favours A, 1 favours B.
  - A pointer updates only on a conflict in its file: it is set to the loser, so the loser wins the next conflict.
  - Non-conflicting grants leave both pointers unchanged.
- **Latency:** accepted in cycle N means the write-port outputs are asserted in cycle N+1. The register file stores the value at the end of N+1, and it is readable in N+2.
- **Output registers:**
  - Every cycle, each file's enable is loaded with "a request to that file was accepted".
  - Address and data are loaded from the accepted request.
  - If nothing is accepted for a file, its enable goes to 0 and its address/data hold their previous value.
- **x0 suppression:** with ZERO_X0 = 1, an accepted GPR request with rd == 0 is still handshaken (ready = 1 per the rules above) but gpr_reg_write stays 0. FPR register 0 is always written.
- **Two enables:** at most one enable per file per cycle; gpr_reg_write and fpr_reg_write may both be 1 in the same cycle.
- **Stall counter:** stall_cnt increments by 1 in each cycle where (a_valid && !a_ready) || (b_valid && !b_ready), i.e. at most +1 per cycle. It saturates at 2^CNT_W-1 and never wraps.
- **Reset (sampled high at an edge, including mid-stream):**
  - All enables, addresses, data and stall_cnt go to 0; both pointers go to 0 (A favoured).
  - While reset = 1: a_ready = b_ready = 0, no request is accepted, and stall_cnt does not count.
  - A write that was registered before the reset edge is dropped (its enable is cleared).
- **No internal buffering:** a refused requester simply holds its request.

Test Plan:
- Reset with a_valid = b_valid = 1 → a_ready = b_ready = 0; cycle after reset deasserts, all outputs 0 and stall_cnt = 0.
- A: GPR rd = 5, data 0x1234_5678; B: FPR rd = 5, data 0x3F80_0000, same cycle → both ready = 1. Next cycle: gpr_reg_write = 1, gpr_write_reg = 5, gpr_write_data = 0x12345678; fpr_reg_write = 1, fpr_write_reg = 5, fpr_write_data = 0x3F800000. stall_cnt = 0.
- Both target GPR for 4 consecutive cycles (each holds its request until accepted, then presents a new one) → grants alternate A, B, A, B; stall_cnt = 4. FPR pointer unchanged (0); a subsequent FPR conflict is won by A.
- A: GPR rd = 0, data 0xDEAD_BEEF, ZERO_X0 = 1 → a_ready = 1; next cycle gpr_reg_write = 0. Same request with FPR rd = 0 → fpr_reg_write = 1.
- Force 2^CNT_W+3 conflict cycles (CNT_W = 4 in the bench) → stall_cnt reaches 15 and holds at 15.
- Accept A: GPR rd = 7 in cycle N, assert reset in N+1 → gpr_reg_write = 0 in N+1 and N+2. A read of GPR reg 7 after reset returns 0.
